// File: rtl/tlb_op_ctrl_pkg.sv
// Shared encodings for the TLB instruction controller:
// op-type codes, FSM state codes and the op-type width.
package tlb_op_ctrl_pkg;

  localparam int TLB_OP_WD = 2;

  localparam logic [TLB_OP_WD-1:0] OP_NONE  = 2'b00;
  localparam logic [TLB_OP_WD-1:0] OP_TLBP  = 2'b01;
  localparam logic [TLB_OP_WD-1:0] OP_TLBR  = 2'b10;
  localparam logic [TLB_OP_WD-1:0] OP_TLBWI = 2'b11;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SRCH  = 3'd1;
  localparam logic [2:0] S_PWB   = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_RWB   = 3'd4;
  localparam logic [2:0] S_WRITE = 3'd5;
  localparam logic [2:0] S_RFCH  = 3'd6;

endpackage

// File: rtl/tlb_op_ctrl.sv
// Sequences TLBP/TLBR/TLBWI from WB: search/read/write the TLB,
// update CP0 and request a refetch after TLBR/TLBWI.
module tlb_op_ctrl
  import tlb_op_ctrl_pkg::*;
#(
  parameter int TLBNUM = 16,
  localparam int IW = $clog2(TLBNUM)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 op_valid,
  output logic                 op_ready,
  input  logic [TLB_OP_WD-1:0] op_type,
  input  logic [31:0]          op_pc,
  input  logic                 flush,
  input  logic [31:0]          cp0_entryhi,
  input  logic [31:0]          cp0_index,
  output logic [18:0]          tlb_s_vpn2,
  output logic [7:0]           tlb_s_asid,
  input  logic                 tlb_s_found,
  input  logic [IW-1:0]        tlb_s_index,
  output logic [IW-1:0]        tlb_r_index,
  output logic                 tlb_we,
  output logic [IW-1:0]        tlb_w_index,
  output logic                 cp0_index_we,
  output logic [31:0]          cp0_index_wdata,
  output logic                 cp0_tlbr_we,
  output logic                 refetch_req,
  output logic [31:0]          refetch_pc,
  output logic                 busy
);

  logic [2:0]    state_q, state_d;
  logic [31:0]   pc_q;
  logic [18:0]   vpn2_q;
  logic [7:0]    asid_q;
  logic [IW-1:0] idx_q;
  logic          found_q;
  logic [IW-1:0] sidx_q;
  logic          accept;
  logic          unused_ok;

  assign unused_ok = ^{cp0_entryhi[12:8], cp0_index[31:IW]};

  assign op_ready = (state_q == S_IDLE) && !flush;
  assign accept   = op_valid && op_ready && (op_type != OP_NONE);
  assign busy     = (state_q != S_IDLE);

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            unique case (1'b1)
              op_type == OP_TLBP: state_d = S_SRCH;
              op_type == OP_TLBR: state_d = S_READ;
              default:            state_d = S_WRITE;
            endcase
          end
        end
        S_SRCH:  state_d = S_PWB;
        S_PWB:   state_d = S_IDLE;
        S_READ:  state_d = S_RWB;
        S_RWB:   state_d = S_RFCH;
        S_WRITE: state_d = S_RFCH;
        S_RFCH:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      vpn2_q  <= '0;
      asid_q  <= '0;
      idx_q   <= '0;
      found_q <= 1'b0;
      sidx_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        pc_q   <= op_pc;
        vpn2_q <= cp0_entryhi[31:13];
        asid_q <= cp0_entryhi[7:0];
        idx_q  <= cp0_index[IW-1:0];
      end
      if (state_q == S_SRCH) begin
        found_q <= tlb_s_found;
        sidx_q  <= tlb_s_index;
      end
    end
  end

  // Strobes are Moore-decoded but a same-cycle flush suppresses them.
  assign tlb_we       = (state_q == S_WRITE) && !flush;
  assign cp0_index_we = (state_q == S_PWB)   && !flush;
  assign cp0_tlbr_we  = (state_q == S_RWB)   && !flush;
  assign refetch_req  = (state_q == S_RFCH)  && !flush;

  assign tlb_s_vpn2  = (state_q == S_SRCH)  ? vpn2_q : '0;
  assign tlb_s_asid  = (state_q == S_SRCH)  ? asid_q : '0;
  assign tlb_r_index = (state_q == S_READ)  ? idx_q  : '0;
  assign tlb_w_index = (state_q == S_WRITE) ? idx_q  : '0;
  assign refetch_pc  = refetch_req ? pc_q + 32'd4 : '0;

  always_comb begin
    cp0_index_wdata = '0;
    if (cp0_index_we) begin
      cp0_index_wdata[31] = ~found_q;
      if (found_q) cp0_index_wdata[IW-1:0] = sidx_q;
    end
  end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Bench for tlb_op_ctrl: per-cycle output records from a
// phase-list model compared against the DUT.
module tb_tlb_op_ctrl;

  localparam int TLBNUM = 16;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic          op_valid;
  logic          op_ready;
  logic [1:0]    op_type;
  logic [31:0]   op_pc;
  logic          flush;
  logic [31:0]   cp0_entryhi;
  logic [31:0]   cp0_index;
  logic [18:0]   tlb_s_vpn2;
  logic [7:0]    tlb_s_asid;
  logic          tlb_s_found;
  logic [IW-1:0] tlb_s_index;
  logic [IW-1:0] tlb_r_index;
  logic          tlb_we;
  logic [IW-1:0] tlb_w_index;
  logic          cp0_index_we;
  logic [31:0]   cp0_index_wdata;
  logic          cp0_tlbr_we;
  logic          refetch_req;
  logic [31:0]   refetch_pc;
  logic          busy;

  tlb_op_ctrl #(.TLBNUM(TLBNUM)) dut (
    .clk(clk), .resetn(resetn),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_type(op_type), .op_pc(op_pc), .flush(flush),
    .cp0_entryhi(cp0_entryhi), .cp0_index(cp0_index),
    .tlb_s_vpn2(tlb_s_vpn2), .tlb_s_asid(tlb_s_asid),
    .tlb_s_found(tlb_s_found), .tlb_s_index(tlb_s_index),
    .tlb_r_index(tlb_r_index),
    .tlb_we(tlb_we), .tlb_w_index(tlb_w_index),
    .cp0_index_we(cp0_index_we),
    .cp0_index_wdata(cp0_index_wdata),
    .cp0_tlbr_we(cp0_tlbr_we),
    .refetch_req(refetch_req), .refetch_pc(refetch_pc),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          ready;
    logic          busy;
    logic [18:0]   svpn2;
    logic [7:0]    sasid;
    logic [IW-1:0] ridx;
    logic          we;
    logic [IW-1:0] widx;
    logic          iwe;
    logic [31:0]   iwdata;
    logic          rwe;
    logic          rf;
    logic [31:0]   rfpc;
  } outs_t;

  typedef enum {
    PH_SRCH, PH_IDXWB, PH_READ, PH_TLBRWB, PH_WRITE, PH_REFETCH
  } ph_e;

  outs_t exp_q[$];
  outs_t obs_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  function automatic outs_t sample();
    outs_t o;
    o.ready  = op_ready;
    o.busy   = busy;
    o.svpn2  = tlb_s_vpn2;
    o.sasid  = tlb_s_asid;
    o.ridx   = tlb_r_index;
    o.we     = tlb_we;
    o.widx   = tlb_w_index;
    o.iwe    = cp0_index_we;
    o.iwdata = cp0_index_wdata;
    o.rwe    = cp0_tlbr_we;
    o.rf     = refetch_req;
    o.rfpc   = refetch_pc;
    return o;
  endfunction

  function automatic outs_t idle_rec();
    outs_t e = '0;
    e.ready = 1'b1;
    return e;
  endfunction

  // Expected cycle-by-cycle records: the accepting idle cycle, then
  // one record per architectural phase; flush at cycle fl kills it.
  task automatic build_exp(input logic [1:0] t, input logic [31:0] pc,
                           input logic [31:0] eh, input logic [31:0] idx,
                           input logic found, input logic [IW-1:0] sidx,
                           input int fl);
    ph_e         ph[$];
    outs_t       e;
    logic [31:0] slot;
    bit          killed;
    slot = idx % TLBNUM;
    case (t)
      2'd1:    ph = '{PH_SRCH, PH_IDXWB};
      2'd2:    ph = '{PH_READ, PH_TLBRWB, PH_REFETCH};
      2'd3:    ph = '{PH_WRITE, PH_REFETCH};
      default: ph.delete();
    endcase
    exp_q.delete();
    exp_q.push_back(idle_rec());
    for (int k = 0; k < ph.size(); k++) begin
      e = '0;
      e.busy = 1'b1;
      killed = (k + 1 == fl);
      case (ph[k])
        PH_SRCH: begin
          e.svpn2 = eh[31:13];
          e.sasid = eh[7:0];
        end
        PH_IDXWB: if (!killed) begin
          e.iwe = 1'b1;
          e.iwdata = found ? {28'd0, sidx} : 32'h8000_0000;
        end
        PH_READ:   e.ridx = slot[IW-1:0];
        PH_TLBRWB: e.rwe = !killed;
        PH_WRITE: begin
          e.widx = slot[IW-1:0];
          e.we = !killed;
        end
        PH_REFETCH: if (!killed) begin
          e.rf = 1'b1;
          e.rfpc = pc + 32'd4;
        end
        default: ;
      endcase
      exp_q.push_back(e);
      if (killed) break;
    end
  endtask

  // Entered and left at posedge+1; busy cycles carry random junk.
  task automatic run_op(input logic [1:0] t, input logic [31:0] pc,
                        input logic [31:0] eh, input logic [31:0] idx,
                        input logic found, input logic [IW-1:0] sidx,
                        input int fl);
    build_exp(t, pc, eh, idx, found, sidx, fl);
    obs_q.delete();
    for (int c = 0; c < exp_q.size(); c++) begin
      if (c == 0) begin
        op_valid = 1'b1; op_type = t; op_pc = pc;
        cp0_entryhi = eh; cp0_index = idx; flush = 1'b0;
      end else begin
        op_valid = 1'($urandom_range(0, 1));
        op_type = 2'($urandom);
        op_pc = $urandom;
        cp0_entryhi = $urandom;
        cp0_index = $urandom;
        flush = (c == fl);
      end
      tlb_s_found = found;
      tlb_s_index = sidx;
      #1;
      obs_q.push_back(sample());
      @(posedge clk);
      #1;
    end
    op_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic test_reset();
    outs_t e;
    resetn = 1'b0; op_valid = 1'b0; op_type = 2'd0; op_pc = '0;
    flush = 1'b0; cp0_entryhi = '0; cp0_index = '0;
    tlb_s_found = 1'b0; tlb_s_index = '0;
    #1;
    n_cmp++;
    if (sample() !== idle_rec()) begin
      n_bad++;
      $display("FAIL reset_idle got %h want %h", sample(), idle_rec());
    end
    flush = 1'b1;
    #1;
    e = '0;
    n_cmp++;
    if (sample() !== e) begin
      n_bad++;
      $display("FAIL reset_flush got %h want %h", sample(), e);
    end
    flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_tlbp_hit();
    run_op(2'd1, 32'h8000_1000, 32'h0040_2012, 32'd0, 1'b1, 4'd5, -1);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL tlbp_hit c%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_tlbp_miss();
    run_op(2'd1, 32'h8000_2000, 32'h1234_50AB, 32'd2, 1'b0, 4'd9, -1);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL tlbp_miss c%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_tlbwi();
    run_op(2'd3, 32'hBFC0_0100, 32'hDEAD_B0EF, 32'h13, 1'b0, 4'd0, -1);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL tlbwi c%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_tlbr();
    run_op(2'd2, 32'hFFFF_FFFC, 32'h0, 32'd7, 1'b1, 4'd1, -1);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL tlbr c%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_flush_read();
    run_op(2'd2, 32'h0000_4000, 32'h0, 32'd7, 1'b0, 4'd0, 1);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL flush_read c%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    #1;
    n_cmp++;
    if (sample() !== idle_rec()) begin
      n_bad++;
      $display("FAIL flush_read_after got %h want %h", sample(), idle_rec());
    end
  endtask

  task automatic test_flush_idle();
    outs_t e = '0;
    op_valid = 1'b1; op_type = 2'd3; cp0_index = 32'd4; flush = 1'b1;
    #1;
    n_cmp++;
    if (sample() !== e) begin
      n_bad++;
      $display("FAIL flush_idle got %h want %h", sample(), e);
    end
    @(posedge clk);
    #1;
    op_valid = 1'b0; flush = 1'b0;
    #1;
    n_cmp++;
    if (sample() !== idle_rec()) begin
      n_bad++;
      $display("FAIL flush_idle_after got %h want %h", sample(), idle_rec());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_none_op();
    run_op(2'd0, 32'h1111_0000, 32'hFFFF_FFFF, 32'd3, 1'b1, 4'd3, -1);
    #1;
    exp_q.push_back(idle_rec());
    obs_q.push_back(sample());
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL none_op c%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] t;
    for (int n = 0; n < 6; n++) begin
      t = 2'($urandom_range(1, 3));
      run_op(t, $urandom, $urandom, $urandom, 1'($urandom), 4'($urandom), -1);
      for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++;
        if (obs_q[i] !== exp_q[i]) begin
          n_bad++;
          $display("FAIL b2b n%0d c%0d got %h want %h", n, i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [1:0]  t;
    logic [31:0] pc;
    int          fl;
    for (int n = 0; n < 60; n++) begin
      t = 2'($urandom_range(0, 3));
      pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : $urandom;
      fl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : -1;
      run_op(t, pc, $urandom, $urandom, 1'($urandom), 4'($urandom), fl);
      for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++;
        if (obs_q[i] !== exp_q[i]) begin
          n_bad++;
          $display("FAIL rand n%0d c%0d got %h want %h", n, i, obs_q[i], exp_q[i]);
        end
      end
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic test_reset_mid_write();
    op_valid = 1'b1; op_type = 2'd3; op_pc = 32'h0000_0100;
    cp0_index = 32'd3; flush = 1'b0;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    #1;
    n_cmp++;
    if (tlb_we !== 1'b1 || tlb_w_index !== 4'd3) begin
      n_bad++;
      $display("FAIL rst_write_pre got we=%b idx=%0d want we=1 idx=3", tlb_we, tlb_w_index);
    end
    resetn = 1'b0;
    #1;
    n_cmp++;
    if (sample() !== idle_rec()) begin
      n_bad++;
      $display("FAIL rst_write_now got %h want %h", sample(), idle_rec());
    end
    @(negedge clk);
    resetn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #2;
      n_cmp++;
      if (sample() !== idle_rec()) begin
        n_bad++;
        $display("FAIL rst_write_after c%0d got %h want %h", c, sample(), idle_rec());
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_tlbp_hit();
    test_tlbp_miss();
    test_tlbwi();
    test_tlbr();
    test_flush_read();
    test_flush_idle();
    test_none_op();
    test_back_to_back();
    test_random();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
